// File: rtl/rc4_pkg.sv
// Shared types and widths for the RC4 input front end: FSM states and the
// tagged plaintext entry stored in the byte FIFO.
package rc4_pkg;

    localparam int KEY_W  = 128;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        KEY     = 2'd0,
        HANDOFF = 2'd1,
        STREAM  = 2'd2
    } fe_state_t;

    typedef struct packed {
        logic              last;
        logic [BYTE_W-1:0] data;
    } fe_entry_t;

endpackage

// File: rtl/rc4_byte_fifo.sv
// Small synchronous FIFO of last-tagged plaintext entries. Power-of-2 depth,
// so pointers wrap naturally; occupancy counter drives full/empty.
module rc4_byte_fifo
    import rc4_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [$bits(fe_entry_t)-1:0] din_i,
    output logic [$bits(fe_entry_t)-1:0] dout_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int ENTRY_W = $bits(fe_entry_t);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_d;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic               push_ok_s;
    logic               pop_ok_s;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == {CNT_W{1'b0}});
    assign push_ok_s = push_i && !full_o;
    assign pop_ok_s  = pop_i && !empty_o;
    assign dout_o    = mem_q[rd_ptr_q];

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_ok_s && !pop_ok_s) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_ok_s && pop_ok_s) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so the head byte is never X
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {ENTRY_W{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/rc4_input_frontend.sv
// Byte-stream front end for the RC4 encryptor: collects the key, hands it over
// with a one-cycle strobe, then feeds buffered plaintext until the last byte.
module rc4_input_frontend
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          rst_n,
    input  logic [BYTE_W-1:0]             in_byte,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic [KEY_BYTES*BYTE_W-1:0]   key,
    output logic                          valid_key,
    input  logic                          ready_for_key,
    output logic [BYTE_W-1:0]             plaintext,
    output logic                          valid_din,
    input  logic                          ready_for_plaintext,
    output logic                          msg_done,
    output logic                          key_err
);

    localparam int KW    = KEY_BYTES * BYTE_W;
    localparam int CNT_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    fe_state_t        state_q;
    fe_state_t        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [KW-1:0]    key_q;
    logic [KW-1:0]    key_d;
    logic             last_seen_q;
    logic             last_seen_d;
    logic             valid_key_q;
    logic             valid_key_d;
    logic             msg_done_q;
    logic             msg_done_d;
    logic             key_err_q;
    logic             key_err_d;

    logic             ready_s;
    logic             accept_s;
    logic             push_s;
    logic             pop_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    fe_entry_t        push_entry_s;
    fe_entry_t        head_s;

    rc4_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .din_i   (push_entry_s),
        .dout_o  (head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Readiness by state; a tagged last byte already queued blocks further input
    always_comb begin
        ready_s = 1'b0;
        case (state_q)
            KEY:     ready_s = 1'b1;
            HANDOFF: ready_s = !fifo_full_s && !last_seen_q;
            STREAM:  ready_s = !fifo_full_s && !last_seen_q;
            default: ready_s = 1'b0;
        endcase
    end

    assign in_ready     = ready_s && rst_n;
    assign accept_s     = in_valid && in_ready;
    assign push_s       = accept_s && (state_q != KEY);
    assign push_entry_s = {in_last, in_byte};
    // Plaintext is held back during the key strobe cycle so the key always lands first
    assign valid_din    = (state_q == STREAM) && !valid_key_q && !fifo_empty_s;
    assign pop_s        = valid_din && ready_for_plaintext;

    // FSM next-state, key shifting and pulse generation
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_d       = key_q;
        last_seen_d = last_seen_q;
        valid_key_d = 1'b0;
        msg_done_d  = 1'b0;
        key_err_d   = 1'b0;
        case (state_q)
            KEY: begin
                if (accept_s && in_last) begin
                    cnt_d     = {CNT_W{1'b0}};
                    key_d     = {KW{1'b0}};
                    key_err_d = 1'b1;
                end else if (accept_s) begin
                    key_d = {in_byte, key_q[KW-1:BYTE_W]};
                    if (cnt_q == CNT_W'(KEY_BYTES - 1)) begin
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = HANDOFF;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = KEY;
                end
            end
            HANDOFF: begin
                if (push_s && in_last) begin
                    last_seen_d = 1'b1;
                end else begin
                    last_seen_d = last_seen_q;
                end
                if (ready_for_key) begin
                    valid_key_d = 1'b1;
                    state_d     = STREAM;
                end else begin
                    state_d = HANDOFF;
                end
            end
            STREAM: begin
                if (pop_s && head_s.last) begin
                    msg_done_d  = 1'b1;
                    last_seen_d = 1'b0;
                    cnt_d       = {CNT_W{1'b0}};
                    state_d     = KEY;
                end else if (push_s && in_last) begin
                    last_seen_d = 1'b1;
                end else begin
                    last_seen_d = last_seen_q;
                end
            end
            default: begin
                state_d     = KEY;
                cnt_d       = {CNT_W{1'b0}};
                key_d       = {KW{1'b0}};
                last_seen_d = 1'b0;
            end
        endcase
    end

    // State, key and strobe registers
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q     <= KEY;
            cnt_q       <= {CNT_W{1'b0}};
            key_q       <= {KW{1'b0}};
            last_seen_q <= 1'b0;
            valid_key_q <= 1'b0;
            msg_done_q  <= 1'b0;
            key_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_q       <= key_d;
            last_seen_q <= last_seen_d;
            valid_key_q <= valid_key_d;
            msg_done_q  <= msg_done_d;
            key_err_q   <= key_err_d;
        end
    end

    assign key       = key_q;
    assign valid_key = valid_key_q;
    assign msg_done  = msg_done_q;
    assign key_err   = key_err_q;
    assign plaintext = head_s.data;

endmodule

// File: tb/tb_rc4_input_frontend.sv
// Directed bench for rc4_input_frontend: a cycle table for the basic message,
// then hand-written sequences for back-pressure, key delay, key error and reset.
module tb_rc4_input_frontend;

    logic         clock = 1'b0;
    logic         rst_n;
    logic [7:0]   in_byte;
    logic         in_valid;
    logic         in_last;
    logic         in_ready;
    logic [127:0] key;
    logic         valid_key;
    logic         ready_for_key;
    logic [7:0]   plaintext;
    logic         valid_din;
    logic         ready_for_plaintext;
    logic         msg_done;
    logic         key_err;

    int n_checks = 0;
    int n_err    = 0;

    rc4_input_frontend #(
        .KEY_BYTES  (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clock               (clock),
        .rst_n               (rst_n),
        .in_byte             (in_byte),
        .in_valid            (in_valid),
        .in_last             (in_last),
        .in_ready            (in_ready),
        .key                 (key),
        .valid_key           (valid_key),
        .ready_for_key       (ready_for_key),
        .plaintext           (plaintext),
        .valid_din           (valid_din),
        .ready_for_plaintext (ready_for_plaintext),
        .msg_done            (msg_done),
        .key_err             (key_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       iv;
        logic [7:0] ib;
        logic       il;
        logic       rfk;
        logic       rfp;
        logic       e_rdy;
        logic       e_vk;
        logic       e_vd;
        logic [7:0] e_pt;
        logic       e_md;
        logic       e_ke;
    } vec_t;

    vec_t vecs [23];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs at the falling edge, then let outputs settle before sampling
    task automatic drive(input logic rst, input logic v, input logic [7:0] b,
                         input logic l, input logic rfk, input logic rfp);
        @(negedge clock);
        rst_n               = rst;
        in_valid            = v;
        in_byte             = b;
        in_last             = l;
        ready_for_key       = rfk;
        ready_for_plaintext = rfp;
        #1;
    endtask

    task automatic send_key(input logic [7:0] base, input logic rfk);
        int misses = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, base + 8'(i), 1'b0, rfk, 1'b0);
            if (!in_ready) misses++;
        end
        chk("key_bytes_ready", 128'(misses), 128'd0);
    endtask

    task automatic run_payload(input string tag, input int n, input logic [7:0] base,
                               input int rfk_at, input int rfp_at, input int exp_block);
        int sent = 0;
        int got = 0;
        int first_block = -1;
        int vk_cnt = 0;
        int vk_cyc = -1;
        int md_cnt = 0;
        int early = 0;
        logic [7:0] exp_b;
        for (int c = 0; c < 60; c++) begin
            drive(1'b1, sent < n, base + 8'(sent), sent == n - 1, c >= rfk_at, c >= rfp_at);
            if (valid_key) begin
                vk_cnt++;
                vk_cyc = c;
            end
            if (valid_din && vk_cnt == 0) early++;
            if (valid_din && ready_for_plaintext) begin
                exp_b = base + 8'(got);
                chk({tag, "_byte"}, 128'(plaintext), 128'(exp_b));
                got++;
            end
            if (msg_done) md_cnt++;
            if (in_valid) begin
                if (in_ready) sent++;
                else if (first_block < 0) first_block = sent;
            end
        end
        chk({tag, "_block_after"}, 128'(first_block), 128'(exp_block));
        chk({tag, "_vk_count"}, 128'(vk_cnt), 128'd1);
        chk({tag, "_vk_cycle"}, 128'(vk_cyc), 128'(rfk_at + 1));
        chk({tag, "_din_early"}, 128'(early), 128'd0);
        chk({tag, "_delivered"}, 128'(got), 128'(n));
        chk({tag, "_msg_done"}, 128'(md_cnt), 128'd1);
    endtask

    initial begin
        logic [12:0] act_v;
        logic [12:0] exp_v;

        rst_n               = 1'b0;
        in_valid            = 1'b0;
        in_byte             = 8'h00;
        in_last             = 1'b0;
        ready_for_key       = 1'b0;
        ready_for_plaintext = 1'b0;

        for (int i = 0; i < 16; i++) begin
            vecs[i] = '{1'b1, 8'(i), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        end
        vecs[16] = '{1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 8'hBB, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 8'hCC, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hBB, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hCC, 1'b0, 1'b0};
        vecs[21] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[22] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

        // Reset state
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b1);
        chk("rst_in_ready", 128'(in_ready), 128'd0);
        chk("rst_pulses", 128'({valid_key, valid_din, msg_done, key_err}), 128'd0);
        chk("rst_key", key, 128'd0);

        // Key 00..0F then AA,BB,CC(last) with both ready inputs high
        for (int i = 0; i < 23; i++) begin
            drive(1'b1, vecs[i].iv, vecs[i].ib, vecs[i].il, vecs[i].rfk, vecs[i].rfp);
            act_v = {in_ready, valid_key, valid_din, (valid_din ? plaintext : 8'h00), msg_done, key_err};
            exp_v = {vecs[i].e_rdy, vecs[i].e_vk, vecs[i].e_vd, vecs[i].e_pt, vecs[i].e_md, vecs[i].e_ke};
            chk($sformatf("vec%0d", i), 128'(act_v), 128'(exp_v));
        end
        chk("t1_key", key, 128'h0F0E0D0C0B0A09080706050403020100);

        // Six bytes against a stalled consumer: FIFO fills after four
        send_key(8'h10, 1'b0);
        run_payload("t3", 6, 8'h60, 0, 8, 4);
        chk("t3_key", key, 128'h1F1E1D1C1B1A19181716151413121110);

        // Encryptor not ready for the key for 20 cycles; plaintext prefills
        send_key(8'h20, 1'b0);
        run_payload("t4", 5, 8'h70, 20, 20, 4);
        chk("t4_key", key, 128'h2F2E2D2C2B2A29282726252423222120);

        // in_last on the 5th key byte aborts key collection
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 8'h90 + 8'(i), 1'b0, 1'b0, 1'b0);
        end
        drive(1'b1, 1'b1, 8'h94, 1'b1, 1'b0, 1'b0);
        chk("t5_no_early_err", 128'(key_err), 128'd0);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t5_key_err", 128'(key_err), 128'd1);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t5_key_err_once", 128'(key_err), 128'd0);
        chk("t5_key_cleared", key, 128'd0);
        send_key(8'h40, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t5_fresh_key", key, 128'h4F4E4D4C4B4A49484746454443424140);
        chk("t5_no_strobe", 128'(valid_key), 128'd0);

        // Reset in the middle of a message with three bytes buffered
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 8'hA0, 1'b0, 1'b1, 1'b0);
        chk("t6_strobe", 128'(valid_key), 128'd1);
        drive(1'b1, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("t6_buffered", 128'({valid_din, plaintext}), 128'({1'b1, 8'hA0}));
        drive(1'b0, 1'b1, 8'hEE, 1'b0, 1'b1, 1'b1);
        chk("t6_ready_in_reset", 128'(in_ready), 128'd0);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("t6_post_rst", 128'({valid_din, in_ready, valid_key}), 128'({1'b0, 1'b1, 1'b0}));
        chk("t6_post_rst_key", key, 128'd0);
        send_key(8'h50, 1'b1);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("t6_new_strobe", 128'(valid_key), 128'd1);
        chk("t6_new_key", key, 128'h5F5E5D5C5B5A59585756555453525150);
        drive(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("t6_fifo_flushed", 128'(valid_din), 128'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
